layer_io_sequencer: RTL

- Drives the parallel activation inputs of one fully-connected layer stage (15 × 32-bit IEEE-754 floats) from a serial valid/ready stream.
- Waits a fixed latency for the stage's registered, ReLU'd outputs, then captures them.
- Streams the captured results back out serially.
- Sits between the stream-based sample fabric and the parallel node/layer modules: it is the producer of their A-inputs and the consumer of their N-outputs.

---
 rtl/layer_io_pkg.sv | 19 +
 rtl/layer_io_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/layer_io_pkg.sv
// Shared definitions for the layer I/O sequencer and the benches that drive it.
//   state_e    : sequencer phases (load activations, wait for node, send results)
//   DATA_W_DEF : default word width
//   FP_*       : single-precision constants handy for stimulus
package layer_io_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO  = 32'h4000_0000;

endpackage

// File: rtl/layer_io_sequencer.sv
// Feeds one fully-connected layer stage: collects NUM_IN words from a serial
// valid/ready stream onto a parallel activation bus, waits NODE_LAT edges for
// the stage's registered outputs, captures NUM_OUT result words and streams
// them back out serially. Words are opaque bits and pass through untouched.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_data/s_valid/s_ready  serial activation input stream
//   a_bus, a_valid        parallel activations (word k at [k*DATA_W +: DATA_W])
//   res_in                node outputs (word j at [j*DATA_W +: DATA_W])
//   m_data/m_valid/m_ready/m_last  serial result output stream
//   busy                  high whenever not loading
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accept activation words into a_bus, one per handshake
// WAIT  | a_bus frozen and valid; count edges until res_in has settled
// SEND  | stream captured results out, word 0 first, m_last on the final one
module layer_io_sequencer
    import layer_io_pkg::*;
#(
    parameter int NUM_IN   = 15,
    parameter int NUM_OUT  = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NODE_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [NUM_IN*DATA_W-1:0]   a_bus,
    output logic                       a_valid,
    input  logic [NUM_OUT*DATA_W-1:0]  res_in,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy
);

    localparam logic [1:0] ST_LOAD = 2'(LOAD);
    localparam logic [1:0] ST_WAIT = 2'(WAIT);
    localparam logic [1:0] ST_SEND = 2'(SEND);

    localparam int IN_W   = (NUM_IN > 1)   ? $clog2(NUM_IN)       : 1;
    localparam int OUT_W  = (NUM_OUT > 1)  ? $clog2(NUM_OUT)      : 1;
    localparam int WAIT_W = (NODE_LAT > 0) ? $clog2(NODE_LAT + 1) : 1;

    localparam logic [IN_W-1:0]   LAST_IN  = IN_W'(NUM_IN - 1);
    localparam logic [OUT_W-1:0]  LAST_OUT = OUT_W'(NUM_OUT - 1);
    localparam logic [WAIT_W-1:0] LAT_TC   = WAIT_W'(NODE_LAT);

    logic [1:0]                  state_q,   state_d;
    logic [IN_W-1:0]             in_idx_q,  in_idx_d;
    logic [OUT_W-1:0]            out_idx_q, out_idx_d;
    logic [WAIT_W-1:0]           wait_q,    wait_d;
    logic [NUM_IN*DATA_W-1:0]    a_bus_q,   a_bus_d;
    logic [NUM_OUT*DATA_W-1:0]   res_buf_q, res_buf_d;
    logic                        a_valid_q, a_valid_d;
    logic                        m_valid_q, m_valid_d;
    logic                        m_last_q,  m_last_d;
    logic [DATA_W-1:0]           m_data_q,  m_data_d;

    assign s_ready = (state_q == ST_LOAD);
    assign busy    = (state_q != ST_LOAD);
    assign a_bus   = a_bus_q;
    assign a_valid = a_valid_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        wait_d    = wait_q;
        a_bus_d   = a_bus_q;
        res_buf_d = res_buf_q;
        a_valid_d = a_valid_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;

        case (state_q)
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    a_bus_d[int'(in_idx_q)*DATA_W +: DATA_W] = s_data;
                    if (in_idx_q == LAST_IN) begin
                        in_idx_d  = '0;
                        wait_d    = '0;
                        a_valid_d = 1'b1;
                        state_d   = ST_WAIT;
                    end else begin
                        in_idx_d = in_idx_q + IN_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Capture one full cycle after the node register has updated.
                if (wait_q == LAT_TC) begin
                    res_buf_d = res_in;
                    out_idx_d = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = res_in[DATA_W-1:0];
                    m_last_d  = (NUM_OUT == 1);
                    state_d   = ST_SEND;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_SEND: begin
                if (m_ready) begin
                    if (out_idx_q == LAST_OUT) begin
                        out_idx_d = '0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        a_valid_d = 1'b0;
                        state_d   = ST_LOAD;
                    end else begin
                        // Preload the next word so m_data stays registered.
                        out_idx_d = out_idx_q + OUT_W'(1);
                        m_data_d  = res_buf_q[int'(out_idx_d)*DATA_W +: DATA_W];
                        m_last_d  = (out_idx_d == LAST_OUT);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            wait_q    <= '0;
            a_bus_q   <= '0;
            res_buf_q <= '0;
            a_valid_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            wait_q    <= wait_d;
            a_bus_q   <= a_bus_d;
            res_buf_q <= res_buf_d;
            a_valid_q <= a_valid_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule
